// File: rtl/arm7tdmi_pkg.sv
// Shared constants and types for the ARM7TDMI exception entry sequencer.
// Exception codes, vector addresses, link-register offsets and the controller state type.
package arm7tdmi_pkg;

    localparam logic [2:0] ExcUnd  = 3'd1;
    localparam logic [2:0] ExcSwi  = 3'd2;
    localparam logic [2:0] ExcPabt = 3'd3;
    localparam logic [2:0] ExcDabt = 3'd4;
    localparam logic [2:0] ExcIrq  = 3'd5;
    localparam logic [2:0] ExcFiq  = 3'd6;

    localparam logic [31:0] VecUnd  = 32'h0000_0004;
    localparam logic [31:0] VecSwi  = 32'h0000_0008;
    localparam logic [31:0] VecPabt = 32'h0000_000C;
    localparam logic [31:0] VecDabt = 32'h0000_0010;
    localparam logic [31:0] VecIrq  = 32'h0000_0018;
    localparam logic [31:0] VecFiq  = 32'h0000_001C;

    localparam logic [31:0] LrOffArm   = 32'd4;
    localparam logic [31:0] LrOffThumb = 32'd2;
    localparam logic [31:0] LrOffAbort = 32'd4;
    localparam logic [31:0] LrOffIrq   = 32'd4;
    localparam logic [31:0] LrOffDabt  = 32'd8;

    typedef enum logic [2:0] {
        StIdle,
        StSave,
        StSwitch,
        StRefill1,
        StRefill2
    } exc_ctrl_state_t;

    function automatic logic is_valid_exc(input logic [2:0] code);
        return (code >= ExcUnd) && (code <= ExcFiq);
    endfunction

endpackage

// File: rtl/arm7tdmi_exc_lr_calc.sv
// Return-address computation for the banked R14 on exception entry.
module arm7tdmi_exc_lr_calc
    import arm7tdmi_pkg::*;
(
    input  logic [2:0]  exc_type_i,
    input  logic [31:0] addr_i,
    input  logic        thumb_i,
    output logic [31:0] lr_o
);

    // Additions wrap mod 2^32 by construction.
    always_comb begin
        lr_o = addr_i + LrOffIrq;
        case (exc_type_i)
            ExcDabt:         lr_o = addr_i + LrOffDabt;
            ExcPabt:         lr_o = addr_i + LrOffAbort;
            ExcSwi, ExcUnd:  lr_o = addr_i + (thumb_i ? LrOffThumb : LrOffArm);
            default:         lr_o = addr_i + LrOffIrq;
        endcase
    end

endmodule

// File: rtl/arm7tdmi_exception_ctrl.sv
// Exception entry sequencer: saves SPSR/LR, switches CPSR/PC, refills the pipe, then acks.
module arm7tdmi_exception_ctrl
    import arm7tdmi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [2:0]  exc_type,
    input  logic [4:0]  exc_mode,
    input  logic [31:0] exc_vector,
    input  logic [31:0] exc_cpsr,
    input  logic [31:0] exc_spsr,
    input  logic [31:0] exc_addr,
    input  logic        thumb,
    input  logic        instr_boundary,
    output logic        spsr_we,
    output logic [4:0]  spsr_mode,
    output logic [31:0] spsr_wdata,
    output logic        lr_we,
    output logic [4:0]  lr_mode,
    output logic [31:0] lr_wdata,
    output logic        cpsr_we,
    output logic [31:0] cpsr_wdata,
    output logic        pc_we,
    output logic [31:0] pc_wdata,
    output logic        pipe_flush,
    output logic        stall,
    output logic        busy,
    output logic        exc_ack
);

    exc_ctrl_state_t state_q, state_d;

    logic [2:0]  type_q;
    logic [4:0]  mode_q;
    logic [31:0] vector_q;
    logic [31:0] cpsr_q;
    logic [31:0] spsr_q;
    logic [31:0] addr_q;
    logic        thumb_q;

    logic        save_q;
    logic        switch_q;
    logic        ack_q;
    logic        accept;
    logic [31:0] lr_calc;

    // Data aborts must be taken mid-instruction; everything else waits for a boundary.
    assign accept = (state_q == StIdle) && exc_req && is_valid_exc(exc_type) &&
                    (instr_boundary || (exc_type == ExcDabt));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StSave;
            StSave:    state_d = StSwitch;
            StSwitch:  state_d = StRefill1;
            StRefill1: state_d = StRefill2;
            StRefill2: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state so each lands exactly in its state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            type_q   <= '0;
            mode_q   <= '0;
            vector_q <= '0;
            cpsr_q   <= '0;
            spsr_q   <= '0;
            addr_q   <= '0;
            thumb_q  <= 1'b0;
            save_q   <= 1'b0;
            switch_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            save_q   <= (state_d == StSave);
            switch_q <= (state_d == StSwitch);
            ack_q    <= (state_d == StRefill2);
            if (accept) begin
                type_q   <= exc_type;
                mode_q   <= exc_mode;
                vector_q <= exc_vector;
                cpsr_q   <= exc_cpsr;
                spsr_q   <= exc_spsr;
                addr_q   <= exc_addr;
                thumb_q  <= thumb;
            end
        end
    end

    arm7tdmi_exc_lr_calc u_lr_calc (
        .exc_type_i (type_q),
        .addr_i     (addr_q),
        .thumb_i    (thumb_q),
        .lr_o       (lr_calc)
    );

    assign spsr_we    = save_q;
    assign spsr_mode  = save_q ? mode_q : '0;
    assign spsr_wdata = save_q ? spsr_q : '0;
    assign lr_we      = save_q;
    assign lr_mode    = save_q ? mode_q : '0;
    assign lr_wdata   = save_q ? lr_calc : '0;

    assign cpsr_we    = switch_q;
    assign cpsr_wdata = switch_q ? cpsr_q : '0;
    assign pc_we      = switch_q;
    assign pc_wdata   = switch_q ? vector_q : '0;
    assign pipe_flush = switch_q;

    assign exc_ack    = ack_q;
    assign busy       = (state_q != StIdle);
    assign stall      = busy;

endmodule

// File: tb/tb_arm7tdmi_exception_ctrl.sv
// Randomised scoreboard bench for the exception entry sequencer.
module tb_arm7tdmi_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req;
    logic [2:0]  exc_type;
    logic [4:0]  exc_mode;
    logic [31:0] exc_vector, exc_cpsr, exc_spsr, exc_addr;
    logic        thumb, instr_boundary;
    logic        spsr_we, lr_we, cpsr_we, pc_we, pipe_flush, stall, busy, exc_ack;
    logic [4:0]  spsr_mode, lr_mode;
    logic [31:0] spsr_wdata, lr_wdata, cpsr_wdata, pc_wdata;

    arm7tdmi_exception_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .exc_req        (exc_req),
        .exc_type       (exc_type),
        .exc_mode       (exc_mode),
        .exc_vector     (exc_vector),
        .exc_cpsr       (exc_cpsr),
        .exc_spsr       (exc_spsr),
        .exc_addr       (exc_addr),
        .thumb          (thumb),
        .instr_boundary (instr_boundary),
        .spsr_we        (spsr_we),
        .spsr_mode      (spsr_mode),
        .spsr_wdata     (spsr_wdata),
        .lr_we          (lr_we),
        .lr_mode        (lr_mode),
        .lr_wdata       (lr_wdata),
        .cpsr_we        (cpsr_we),
        .cpsr_wdata     (cpsr_wdata),
        .pc_we          (pc_we),
        .pc_wdata       (pc_wdata),
        .pipe_flush     (pipe_flush),
        .stall          (stall),
        .busy           (busy),
        .exc_ack        (exc_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] addr;
        logic        thumb;
        logic [4:0]  mode;
        logic [31:0] vector;
        logic [31:0] cpsr;
        logic [31:0] spsr;
        int          cyc;
    } txn_t;

    txn_t exp_q[$];

    function automatic logic [4:0] ref_mode(input logic [2:0] t);
        case (t)
            3'd1:       return 5'h1B;
            3'd2:       return 5'h13;
            3'd3, 3'd4: return 5'h17;
            3'd5:       return 5'h12;
            3'd6:       return 5'h11;
            default:    return 5'h00;
        endcase
    endfunction

    function automatic logic [31:0] ref_vector(input logic [2:0] t);
        return 32'(t) * 32'd4 + ((t >= 3'd5) ? 32'd4 : 32'd0);
    endfunction

    function automatic logic [31:0] ref_lr(input logic [2:0] t, input logic [31:0] a,
                                           input logic th);
        if (t == 3'd4) return a + 32'd8;
        if ((t == 3'd1 || t == 3'd2) && th) return a + 32'd2;
        return a + 32'd4;
    endfunction

    function automatic txn_t mk(input logic [2:0] t, input logic [31:0] a, input logic th);
        txn_t x;
        x.typ    = t;
        x.addr   = a;
        x.thumb  = th;
        x.mode   = ref_mode(t);
        x.vector = ref_vector(t);
        x.cpsr   = {$urandom} & 32'hFFFF_FFE0 | 32'(x.mode);
        x.spsr   = $urandom;
        x.cyc    = 0;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input txn_t t, input logic bnd);
        exc_req        = 1'b1;
        exc_type       = t.typ;
        exc_mode       = t.mode;
        exc_vector     = t.vector;
        exc_cpsr       = t.cpsr;
        exc_spsr       = t.spsr;
        exc_addr       = t.addr;
        thumb          = t.thumb;
        instr_boundary = bnd;
    endtask

    task automatic expect_at(input txn_t t, input int accept_cyc);
        txn_t x;
        x     = t;
        x.cyc = accept_cyc;
        exp_q.push_back(x);
    endtask

    task automatic wait_ack();
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exc_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
    endtask

    // Called just after a rising edge with the DUT idle; leaves the same alignment.
    task automatic run_one(input txn_t t, input logic bnd);
        drive(t, bnd);
        if (!bnd && t.typ != 3'd4) begin
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            instr_boundary = 1'b1;
        end
        expect_at(t, cyc + 1);
        wait_ack();
        @(posedge clk);
        #1;
        exc_req        = 1'b0;
        instr_boundary = 1'b0;
    endtask

    // Monitor: walks each accepted sequence cycle by cycle against the scoreboard.
    bit   mon_en = 0;
    int   phase  = 0;
    txn_t cur;

    always @(negedge clk) begin
        if (!mon_en) begin
            phase = 0;
        end else begin
            case (phase)
                0: begin
                    if (spsr_we) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_save", 32'd1, 32'd0);
                        end else begin
                            cur = exp_q.pop_front();
                            check("accept_cycle", 32'(cyc), 32'(cur.cyc));
                            check("spsr_wdata", spsr_wdata, cur.spsr);
                            check("spsr_mode", 32'(spsr_mode), 32'(cur.mode));
                            check("lr_we", 32'(lr_we), 32'd1);
                            check("lr_mode", 32'(lr_mode), 32'(cur.mode));
                            check("lr_wdata", lr_wdata, ref_lr(cur.typ, cur.addr, cur.thumb));
                            check("save_other", 32'({cpsr_we, pc_we, pipe_flush, exc_ack}), 0);
                            check("save_busy", 32'({busy, stall}), 32'd3);
                        end
                        phase = 1;
                    end else begin
                        check("idle_ctl", 32'({lr_we, cpsr_we, pc_we, pipe_flush, exc_ack,
                                               busy, stall}), 32'd0);
                        check("idle_data", spsr_wdata | lr_wdata | cpsr_wdata | pc_wdata |
                                           32'({spsr_mode, lr_mode}), 32'd0);
                    end
                end
                1: begin
                    check("switch_ctl", 32'({cpsr_we, pc_we, pipe_flush, spsr_we, lr_we,
                                             exc_ack}), 32'b111000);
                    check("cpsr_wdata", cpsr_wdata, cur.cpsr);
                    check("pc_wdata", pc_wdata, cur.vector);
                    phase = 2;
                end
                2: begin
                    check("refill1_ctl", 32'({spsr_we, lr_we, cpsr_we, pc_we, pipe_flush,
                                              exc_ack, busy, stall}), 32'd3);
                    check("refill1_data", spsr_wdata | lr_wdata | cpsr_wdata | pc_wdata, 0);
                    phase = 3;
                end
                default: begin
                    check("refill2_ack", 32'({exc_ack, busy, spsr_we, cpsr_we}), 32'b1100);
                    phase = 0;
                end
            endcase
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        txn_t t1, t2;
        logic [2:0]  rt;
        logic [31:0] ra;
        int gap;

        rst = 1'b1;
        exc_req = 1'b0; exc_type = '0; exc_mode = '0; exc_vector = '0;
        exc_cpsr = '0; exc_spsr = '0; exc_addr = '0; thumb = 1'b0; instr_boundary = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", 32'({spsr_we, lr_we, cpsr_we, pc_we, pipe_flush, exc_ack,
                                busy, stall}), 32'd0);
        check("reset_data", spsr_wdata | lr_wdata | cpsr_wdata | pc_wdata, 32'd0);

        // Request present in the same cycle as reset is dropped.
        drive(mk(3'd5, 32'h100, 1'b0), 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exc_req = 1'b0;
        mon_en = 1;
        @(negedge clk);
        check("req_in_reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        run_one(mk(3'd5, 32'h0000_0100, 1'b0), 1'b1);
        run_one(mk(3'd4, 32'hFFFF_FFFC, 1'b0), 1'b0);
        run_one(mk(3'd2, 32'h0000_2000, 1'b1), 1'b1);
        run_one(mk(3'd1, 32'h0000_2000, 1'b0), 1'b1);
        run_one(mk(3'd3, 32'h0000_3000, 1'b1), 1'b0);

        // FIQ arrives while the IRQ sequence is running; it must wait for the ack.
        t1 = mk(3'd5, 32'h300, 1'b0);
        t2 = mk(3'd6, 32'h400, 1'b1);
        drive(t1, 1'b1);
        expect_at(t1, cyc + 1);
        @(posedge clk);
        #1;
        drive(t2, 1'b1);
        expect_at(t2, cyc + 5);
        wait_ack();
        wait_ack();
        @(posedge clk);
        #1;
        exc_req = 1'b0;

        // Reserved codes never start a sequence.
        for (int k = 0; k < 2; k++) begin
            exc_req = 1'b1;
            exc_type = (k == 0) ? 3'd0 : 3'd7;
            instr_boundary = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check("invalid_busy", 32'(busy), 32'd0);
                check("invalid_we", 32'({spsr_we, lr_we, cpsr_we, pc_we}), 32'd0);
            end
            @(posedge clk);
            #1;
            exc_req = 1'b0;
            instr_boundary = 1'b0;
        end

        // Reset asserted during the SWITCH cycle aborts cleanly.
        mon_en = 0;
        drive(mk(3'd5, 32'h500, 1'b0), 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("rst_test_save", 32'(spsr_we), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exc_req = 1'b0;
        @(negedge clk);
        check("rst_test_switch", 32'(pc_we), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_abort_ctl", 32'({spsr_we, lr_we, cpsr_we, pc_we, pipe_flush, exc_ack,
                                    busy, stall}), 32'd0);
        check("rst_abort_data", spsr_wdata | lr_wdata | cpsr_wdata | pc_wdata, 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("rst_no_ack", 32'({exc_ack, busy}), 32'd0);
        end
        @(posedge clk);
        #1;
        mon_en = 1;

        for (int n = 0; n < 30; n++) begin
            rt = 3'($urandom_range(1, 6));
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF0 | ({$urandom} & 32'hE);
            else ra = $urandom;
            run_one(mk(rt, ra, 1'($urandom_range(0, 1))), 1'($urandom_range(0, 1)));
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm7tdmi_exception_ctrl.md
ARM7TDMI_EXCEPTION_CTRL -- requirements
Module: arm7tdmi_exception_ctrl

Interface
REQ-001 SHALL have clk, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have exc_req, input, 1: prioritised exception pending (level, held by source until exc_ack).
REQ-004 SHALL have exc_type, input, 3: exception code (1 UND, 2 SWI, 3 PABT, 4 DABT, 5 IRQ, 6 FIQ).
REQ-005 SHALL have exc_mode, input, 5; exc_vector, input, 32; exc_cpsr, input, 32; exc_spsr, input, 32: target mode, vector, new CPSR and old CPSR from the priority unit.
REQ-006 SHALL have exc_addr, input, 32: address of the interrupted, faulting or SWI/UND instruction.
REQ-007 SHALL have thumb, input, 1: core was in Thumb state; instr_boundary, input, 1: core at instruction boundary.
REQ-008 SHALL have spsr_we, output, 1; spsr_mode, output, 5; spsr_wdata, output, 32: banked SPSR write.
REQ-009 SHALL have lr_we, output, 1; lr_mode, output, 5; lr_wdata, output, 32: banked R14 write.
REQ-010 SHALL have cpsr_we, output, 1; cpsr_wdata, output, 32; pc_we, output, 1; pc_wdata, output, 32.
REQ-011 SHALL have pipe_flush, output, 1; stall, output, 1; busy, output, 1; exc_ack, output, 1.

Function
REQ-012 States SHALL be IDLE, SAVE, SWITCH, REFILL1, REFILL2.
REQ-013 IDLE->SAVE SHALL occur when exc_req=1 and either instr_boundary=1 or exc_type=DABT; all exc_* inputs, exc_addr and thumb are captured on that edge.
REQ-014 SAVE SHALL assert spsr_we and lr_we for exactly one cycle, using captured values: spsr_wdata=exc_spsr, spsr_mode=lr_mode=exc_mode.
REQ-015 lr_wdata SHALL be exc_addr+4 for IRQ, FIQ and PABT; exc_addr+8 for DABT; exc_addr+4 (ARM) or exc_addr+2 (Thumb) for SWI and UND. The sum is mod 2^32 and wraps silently.
REQ-016 SWITCH SHALL assert cpsr_we (cpsr_wdata=exc_cpsr), pc_we (pc_wdata=exc_vector) and pipe_flush for exactly one cycle.
REQ-017 REFILL1 and REFILL2 SHALL each last one cycle. exc_ack SHALL pulse for one cycle in REFILL2, and the next state is IDLE.
REQ-018 Latency: accept at edge N; spsr/lr write in cycle N+1, cpsr/pc/flush in N+2, exc_ack in N+4. The earliest next accept is at edge N+5.
REQ-019 busy and stall SHALL be 1 in all states except IDLE.
REQ-020 exc_req changes while busy=1 SHALL be ignored: no re-capture and no abort of the sequence. A still-pending higher-priority request is taken from IDLE after exc_ack.
REQ-021 Write enables, pipe_flush and exc_ack SHALL be registered outputs and glitch-free. Data outputs SHALL be 0 in any cycle where their enable is 0.
REQ-022 exc_type values 0 and 7 with exc_req=1 SHALL NOT be accepted; the block stays in IDLE.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE and clear captured registers. It SHALL drive every output to 0 from the next cycle, including mid-sequence, with no partial writes.
REQ-024 An exc_req sampled in the same cycle as rst=1 SHALL be discarded.

Structure
REQ-025 arm7tdmi_pkg SHALL hold the exception type codes, the vector constants, the LR offset constants and the state enum typedef exc_ctrl_state_t.
REQ-026 LR computation SHALL be a combinational sub-module arm7tdmi_exc_lr_calc (inputs type, addr, thumb; output lr).

Verification
REQ-027 IRQ: exc_addr=0x100, ARM, boundary=1 -> N+1 lr_wdata=0x104, spsr_mode=0x12; N+2 pc_wdata=0x18, pipe_flush=1; N+4 exc_ack=1.
REQ-028 DABT with instr_boundary=0, exc_addr=0xFFFFFFFC -> accepted immediately, lr_wdata=0x00000004 (wrap), pc_wdata=0x10.
REQ-029 Thumb SWI at 0x2000 -> lr_wdata=0x2002; UND ARM at 0x2000 -> lr_wdata=0x2004, lr_mode=0x1B.
REQ-030 FIQ asserted during an IRQ sequence -> no disturbance; FIQ is accepted at edge N+5, pc_wdata=0x1C.
REQ-031 rst=1 in SWITCH cycle -> next cycle all outputs 0, state IDLE, no exc_ack.
REQ-032 exc_req=1 with exc_type=0 or 7 -> busy stays 0, no write enables.
